cla_adde16b: RTL and testbench
==============================

CLA_ADDE16B -- requirements
Module: cla_adde16b

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port a, input, 16 bits: operand A, two's complement.
REQ-004 SHALL have port b, input, 16 bits: operand B, two's complement.
REQ-005 SHALL have port op, input, 3 bits: operation select.
REQ-006 SHALL have port r, output, 16 bits: registered result.
REQ-007 SHALL have port c_out, output, 1 bit: registered carry out of bit 15.
REQ-008 SHALL have port overflow, output, 1 bit: registered signed-overflow flag.
REQ-009 SHALL have port zero, output, 1 bit: registered flag, 1 when r equals 0.
REQ-010 SHALL provide one clock and one synchronous active-high reset (rst); no other clocks or resets.

Function
REQ-011 SHALL compute from a, b and op combinationally, and register r, c_out, overflow and zero on each rising clk edge; latency is exactly 1 cycle, with no enable and no handshake.
REQ-012 For op 000 (AND): r = a & b, c_out = 0, overflow = 0.
REQ-013 For op 001 (OR): r = a | b, c_out = 0, overflow = 0.
REQ-014 For op 010 (ADD): r = (a + b) mod 2^16, c_out = carry out of bit 15, overflow = 1 iff a[15] == b[15] and r[15] != a[15].
REQ-015 For op 110 (SUB): r = a + ~b + 1 mod 2^16, c_out = carry out of bit 15 of that sum (1 when no borrow), overflow = 1 iff a[15] != b[15] and r[15] != a[15].
REQ-016 For op 111 (SLT, signed): r = 16'h0001 if a < b signed, else 16'h0000; the comparison SHALL be derived from the internal subtraction as sum[15] XOR sub_overflow; c_out = 0, overflow = 0.
REQ-017 For ops 011, 100 and 101 (unused): r = 0, c_out = 0, overflow = 0, zero = 1.
REQ-018 zero SHALL be 1 iff the next registered r equals 16'h0000, for every op.
REQ-019 The adder SHALL be a carry-lookahead adder: four 4-bit lookahead groups producing group propagate/generate, plus a second-level lookahead unit producing the group carries; no ripple chain across groups.
REQ-020 ADD, SUB and SLT SHALL share one adder; B inversion and carry-in = 1 are selected by op.
REQ-021 Boundary cases: 0x7FFF + 1 gives r = 0x8000, overflow = 1; 0xFFFF + 1 gives r = 0, c_out = 1, zero = 1; 0x8000 - 1 gives overflow = 1; SLT of 0x8000 vs 0x7FFF gives r = 1.

Reset
REQ-022 When rst is high at a rising clk edge, SHALL set r = 0, c_out = 0, overflow = 0 and zero = 1, overriding all computation.
REQ-023 Deassertion of rst SHALL resume normal operation; the first valid result appears one cycle after the first non-reset edge.

Structure
REQ-024 SHALL place the opcode constants (OP_AND = 000, OP_OR = 001, OP_ADD = 010, OP_SUB = 110, OP_SLT = 111) and the width parameter (16) in a shared package, cla_alu_pkg.
REQ-025 SHALL use one sub-module, cla_block4: a 4-bit carry-lookahead slice with inputs a[3:0], b[3:0] and cin, and outputs sum[3:0], group P and group G; it is instantiated four times.
REQ-026 The second-level lookahead unit, op decode, result mux and flag logic SHALL reside in cla_adde16b.

Verification
REQ-027 ADD: a = 1, b = 2; a = 20000, b = 14; a = 12356, b = 14500 -> one cycle later r = 3, 20014, 26856 respectively, overflow = 0.
REQ-028 Overflow on ADD: a = 30000, b = 30000 -> overflow = 1; a = -30000, b = -30000 -> overflow = 1; a = 1, b = 2 -> overflow = 0.
REQ-029 AND/zero: a = 0x8888, b = 0x8889 -> r = 0x8888, zero = 0; a = 0xFFFF, b = 0 -> r = 0, zero = 1.
REQ-030 SUB/OR: SUB a = 8, b = 4 -> r = 4, zero = 0; SUB 21 - 3 -> r = 18; OR 0xAAAA | 0x5555 -> r = 0xFFFF; OR 0xF0F0 | 0xF0F1 -> r = 0xF0F1.
REQ-031 SLT: a = 0, b = 8 -> r = 1; a = 8, b = 0 -> r = 0; a = 0x8000, b = 0x7FFF -> r = 1.
REQ-032 Reset: apply rst mid-stream with ADD 1 + 2 pending -> r = 0, zero = 1, c_out = 0, overflow = 0 on that edge, and r = 3 one cycle after rst is released.

Source files
------------

// File: rtl/cla_alu_pkg.sv
// cla_alu_pkg -- shared constants for the 16-bit carry-lookahead ALU.
//   WIDTH      : datapath width
//   GROUP_W    : width of one first-level lookahead slice
//   NUM_GROUPS : number of slices that make up the datapath
//   op_e       : operation select encodings used on the op port
package cla_alu_pkg;

  localparam int WIDTH      = 16;
  localparam int GROUP_W    = 4;
  localparam int NUM_GROUPS = WIDTH / GROUP_W;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

endpackage

// File: rtl/cla_block4.sv
// cla_block4 -- 4-bit carry-lookahead slice.
//   a, b  : 4-bit operand slices (b already inverted by the caller for subtract)
//   cin   : carry into bit 0 of the slice
//   sum   : 4-bit sum
//   p_grp : group propagate (carry-in passes through the whole slice)
//   g_grp : group generate (slice produces a carry-out on its own)
// Internal carries are full lookahead expressions of cin, so no bit waits
// on a neighbouring sum bit.
module cla_block4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       p_grp,
  output logic       g_grp
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

  assign p_grp = &p;
  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adde16b.sv
// cla_adde16b -- 16-bit ALU built on a two-level carry-lookahead adder,
// with all outputs registered (one cycle latency, no handshake).
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   a, b     : two's-complement operands
//   op       : operation select (AND, OR, ADD, SUB, SLT; others give 0)
//   r        : registered result
//   c_out    : registered carry out of bit 15 (ADD/SUB only)
//   overflow : registered signed overflow (ADD/SUB only)
//   zero     : registered flag, set when r is 0
module cla_adde16b
  import cla_alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  // Shared adder: SUB and SLT both compute a + ~b + 1.
  logic                  sub_mode;
  logic [WIDTH-1:0]      b_eff;
  logic [WIDTH-1:0]      sum;
  logic [NUM_GROUPS-1:0] p_grp;
  logic [NUM_GROUPS-1:0] g_grp;
  logic [NUM_GROUPS-1:0] grp_cin;
  logic                  cin0;
  logic                  carry16;
  logic                  adder_ovf;
  logic                  slt;

  assign sub_mode = (op == OP_SUB) || (op == OP_SLT);
  assign b_eff    = sub_mode ? ~b : b;
  assign cin0     = sub_mode;

  // Second-level lookahead: every group carry is a flat function of the
  // group P/G terms and cin0.
  assign grp_cin[0] = cin0;
  assign grp_cin[1] = g_grp[0] | (p_grp[0] & cin0);
  assign grp_cin[2] = g_grp[1] | (p_grp[1] & g_grp[0])
                    | (p_grp[1] & p_grp[0] & cin0);
  assign grp_cin[3] = g_grp[2] | (p_grp[2] & g_grp[1])
                    | (p_grp[2] & p_grp[1] & g_grp[0])
                    | (p_grp[2] & p_grp[1] & p_grp[0] & cin0);
  assign carry16    = g_grp[3] | (p_grp[3] & g_grp[2])
                    | (p_grp[3] & p_grp[2] & g_grp[1])
                    | (p_grp[3] & p_grp[2] & p_grp[1] & g_grp[0])
                    | (p_grp[3] & p_grp[2] & p_grp[1] & p_grp[0] & cin0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_slice
      cla_block4 u_blk (
        .a     (a[gi*GROUP_W +: GROUP_W]),
        .b     (b_eff[gi*GROUP_W +: GROUP_W]),
        .cin   (grp_cin[gi]),
        .sum   (sum[gi*GROUP_W +: GROUP_W]),
        .p_grp (p_grp[gi]),
        .g_grp (g_grp[gi])
      );
    end
  endgenerate

  // Using b_eff makes one expression cover both ADD (signs equal) and
  // SUB (signs differ) overflow.
  assign adder_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // Signed less-than from the subtraction: sign of the difference,
  // corrected when the difference overflowed.
  assign slt = sum[WIDTH-1] ^ adder_ovf;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic             c_out_d;
  logic             c_out_q;
  logic             overflow_d;
  logic             overflow_q;
  logic             zero_d;
  logic             zero_q;

  always_comb begin
    r_d        = '0;
    c_out_d    = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OP_AND: r_d = a & b;
      OP_OR:  r_d = a | b;
      OP_ADD, OP_SUB: begin
        r_d        = sum;
        c_out_d    = carry16;
        overflow_d = adder_ovf;
      end
      OP_SLT: r_d = {{(WIDTH-1){1'b0}}, slt};
      default: r_d = '0;
    endcase
    zero_d = (r_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      r_q        <= r_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign r        = r_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_cla_adde16b.sv
// Scoreboard bench for cla_adde16b: the driver pushes the expected result
// of each applied input vector, the monitor pops and compares one cycle later.
module tb_cla_adde16b;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic [15:0] r;
  logic        c_out;
  logic        overflow;
  logic        zero;

  cla_adde16b dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .op       (op),
    .r        (r),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input bit r_in, input logic [2:0] o,
                                 input logic [15:0] x, input logic [15:0] y,
                                 input string tag);
    exp_t e;
    int   sx;
    int   sy;
    int   ux;
    int   uy;
    int   t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    e.r = 16'h0000;
    e.c = 1'b0;
    e.v = 1'b0;
    e.tag = tag;
    case (o)
      3'b000: e.r = x & y;
      3'b001: e.r = x | y;
      3'b010: begin
        t   = ux + uy;
        e.r = t[15:0];
        e.c = (t > 65535);
        e.v = ((sx + sy) > 32767) || ((sx + sy) < -32768);
      end
      3'b110: begin
        t   = ux - uy;
        e.r = t[15:0];
        e.c = (ux >= uy);
        e.v = ((sx - sy) > 32767) || ((sx - sy) < -32768);
      end
      3'b111: e.r = (sx < sy) ? 16'h0001 : 16'h0000;
      default: e.r = 16'h0000;
    endcase
    e.z = (e.r == 16'h0000);
    if (r_in) begin
      e.r = 16'h0000;
      e.c = 1'b0;
      e.v = 1'b0;
      e.z = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input bit r_in, input logic [2:0] o,
                       input logic [15:0] x, input logic [15:0] y,
                       input string tag);
    rst = r_in;
    op  = o;
    a   = x;
    b   = y;
    q.push_back(model(r_in, o, x, y, tag));
    @(negedge clk);
  endtask

  // Monitor: result of the vector applied before a rising edge is visible
  // just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (r !== e.r || c_out !== e.c || overflow !== e.v || zero !== e.z) begin
          errors++;
          $display("FAIL %s: got r=%h c=%b v=%b z=%b, expected r=%h c=%b v=%b z=%b",
                   e.tag, r, c_out, overflow, zero, e.r, e.c, e.v, e.z);
        end else begin
          $display("ok   %s: r=%h c=%b v=%b z=%b", e.tag, r, c_out, overflow, zero);
        end
      end
    end
  end

  logic [15:0] edge_vals [5];

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    int wait_cyc;
    logic [2:0] ro;
    edge_vals[0] = 16'h0000;
    edge_vals[1] = 16'h0001;
    edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000;
    edge_vals[4] = 16'hFFFF;

    drive(1'b1, 3'b010, 16'd1, 16'd2, "reset0");
    drive(1'b1, 3'b000, 16'h0, 16'h0, "reset1");
    // ADD values
    drive(1'b0, 3'b010, 16'd1, 16'd2, "add_1_2");
    drive(1'b0, 3'b010, 16'd20000, 16'd14, "add_20000_14");
    drive(1'b0, 3'b010, 16'd12356, 16'd14500, "add_12356_14500");
    drive(1'b0, 3'b010, 16'd30000, 16'd30000, "add_ovf_pos");
    drive(1'b0, 3'b010, 16'(-30000), 16'(-30000), "add_ovf_neg");
    // AND / zero
    drive(1'b0, 3'b000, 16'h8888, 16'h8889, "and_8888");
    drive(1'b0, 3'b000, 16'hFFFF, 16'h0000, "and_zero");
    // SUB / OR
    drive(1'b0, 3'b110, 16'd8, 16'd4, "sub_8_4");
    drive(1'b0, 3'b110, 16'd21, 16'd3, "sub_21_3");
    drive(1'b0, 3'b001, 16'hAAAA, 16'h5555, "or_aaaa");
    drive(1'b0, 3'b001, 16'hF0F0, 16'hF0F1, "or_f0f0");
    // SLT
    drive(1'b0, 3'b111, 16'd0, 16'd8, "slt_0_8");
    drive(1'b0, 3'b111, 16'd8, 16'd0, "slt_8_0");
    drive(1'b0, 3'b111, 16'h8000, 16'h7FFF, "slt_min_max");
    // Boundaries
    drive(1'b0, 3'b010, 16'h7FFF, 16'h0001, "add_7fff_1");
    drive(1'b0, 3'b010, 16'hFFFF, 16'h0001, "add_ffff_1");
    drive(1'b0, 3'b110, 16'h8000, 16'h0001, "sub_8000_1");
    // Unused opcodes
    drive(1'b0, 3'b011, 16'h1234, 16'h5678, "unused_011");
    drive(1'b0, 3'b100, 16'hFFFF, 16'hFFFF, "unused_100");
    drive(1'b0, 3'b101, 16'h0F0F, 16'h00FF, "unused_101");
    // Reset mid-stream with ADD 1+2 pending, then release
    drive(1'b0, 3'b001, 16'hFFFF, 16'h0000, "pre_reset");
    drive(1'b1, 3'b010, 16'd1, 16'd2, "mid_reset");
    drive(1'b0, 3'b010, 16'd1, 16'd2, "post_reset");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: ro = 3'b000;
        1: ro = 3'b001;
        2, 3: ro = 3'b010;
        4, 5: ro = 3'b110;
        6: ro = 3'b111;
        default: ro = 3'($urandom_range(3, 5));
      endcase
      drive(($urandom_range(0, 29) == 0), ro, pick(), pick(), $sformatf("rnd%0d", i));
    end

    rst = 1'b0;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
